// File: rtl/controle_memoria_principal.sv
// Main-memory responder: 16 x 3-bit store serving one cache request at a time after LATENCY wait cycles.
// Optional feature MEM_CLEAR_ON_RESET_EN: reset sweeps zeros into the store through an INIT state.
module controle_memoria_principal #(
   parameter int LATENCY = 2
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_wren,
   input  logic [3:0] req_address,
   input  logic [2:0] req_data,
   output logic       resp_valid,
   output logic [2:0] resp_data,
   output logic       busy,
   output logic [1:0] debug_state
);

`ifdef MEM_CLEAR_ON_RESET_EN
   typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, INIT = 2'd2} state_t;
   localparam state_t RESET_STATE = INIT;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1} state_t;
   localparam state_t RESET_STATE = IDLE;
`endif

   localparam logic [3:0] COUNT_LOAD = 4'(LATENCY - 1);

   // Handshake: a request transfers on a rising edge where req_valid && req_ready;
   // the requester holds req_valid until then, nothing is queued while busy.

   logic [2:0] mem [16];
   state_t     state;
   logic [3:0] count;
   logic       lat_wren;
   logic [3:0] lat_address;
   logic [2:0] lat_data;
   logic       done;

`ifdef MEM_CLEAR_ON_RESET_EN
   logic [3:0] init_address;
`endif

   assign req_ready   = (state == IDLE);
   assign busy        = (state != IDLE);
   assign debug_state = state;
   assign done        = (state == WAIT) && (count == 4'd0);

   // Storage has no reset: an aborted write simply never reaches it.
   always_ff @(posedge clock) begin
      if (!reset) begin
         if (done && lat_wren)
            mem[lat_address] <= lat_data;
`ifdef MEM_CLEAR_ON_RESET_EN
         else if (state == INIT)
            mem[init_address] <= 3'b000;
`endif
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= RESET_STATE;
         count      <= 4'd0;
         resp_valid <= 1'b0;
         resp_data  <= 3'b000;
`ifdef MEM_CLEAR_ON_RESET_EN
         init_address <= 4'd0;
`endif
      end else begin
         resp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  lat_wren    <= req_wren;
                  lat_address <= req_address;
                  lat_data    <= req_data;
                  count       <= COUNT_LOAD;
                  state       <= WAIT;
               end
            end
            WAIT: begin
               if (count != 4'd0) begin
                  count <= count - 4'd1;
               end else begin
                  resp_valid <= 1'b1;
                  resp_data  <= lat_wren ? lat_data : mem[lat_address];
                  state      <= IDLE;
               end
            end
`ifdef MEM_CLEAR_ON_RESET_EN
            INIT: begin
               init_address <= init_address + 4'd1;
               if (init_address == 4'd15)
                  state <= IDLE;
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_controle_memoria_principal.sv
// Directed bench for controle_memoria_principal: LATENCY=2 main instance plus LATENCY=1 and 15 timing probes.
// Covers the MEM_CLEAR_ON_RESET_EN build when that macro is defined.
module tb_controle_memoria_principal;

   logic       clock = 1'b0;
   logic       reset;
   logic       req_wren;
   logic [3:0] req_address;
   logic [2:0] req_data;
   logic       v2, v1, v15;
   logic       r2, r1, r15;
   logic       rv2, rv1, rv15;
   logic [2:0] rd2, rd1, rd15;
   logic       b2, b1, b15;
   logic [1:0] ds2, ds1, ds15;

   int passed = 0;
   int total  = 0;

   always #5 clock = ~clock;

   controle_memoria_principal #(.LATENCY(2)) dut (
      .clock(clock), .reset(reset), .req_valid(v2), .req_ready(r2), .req_wren(req_wren),
      .req_address(req_address), .req_data(req_data), .resp_valid(rv2), .resp_data(rd2),
      .busy(b2), .debug_state(ds2));

   controle_memoria_principal #(.LATENCY(1)) dut_lat1 (
      .clock(clock), .reset(reset), .req_valid(v1), .req_ready(r1), .req_wren(req_wren),
      .req_address(req_address), .req_data(req_data), .resp_valid(rv1), .resp_data(rd1),
      .busy(b1), .debug_state(ds1));

   controle_memoria_principal #(.LATENCY(15)) dut_lat15 (
      .clock(clock), .reset(reset), .req_valid(v15), .req_ready(r15), .req_wren(req_wren),
      .req_address(req_address), .req_data(req_data), .resp_valid(rv15), .resp_data(rd15),
      .busy(b15), .debug_state(ds15));

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // One request on the LATENCY=2 instance, inputs scrambled while it is in flight.
   task automatic transact(input string tag, input logic wren, input logic [3:0] addr,
                           input logic [2:0] data, input logic [2:0] exp);
      req_wren = wren; req_address = addr; req_data = data; v2 = 1'b1;
      tick;
      v2 = 1'b0; req_wren = ~wren; req_address = ~addr; req_data = ~data;
      check({tag, "_busy"}, 8'(b2), 8'd1);
      check({tag, "_ready_wait"}, 8'(r2), 8'd0);
      check({tag, "_rv_e1"}, 8'(rv2), 8'd0);
      tick;
      check({tag, "_rv_e2"}, 8'(rv2), 8'd0);
      tick;
      check({tag, "_rv_resp"}, 8'(rv2), 8'd1);
      check({tag, "_data"}, 8'(rd2), 8'(exp));
      tick;
      check({tag, "_rv_after"}, 8'(rv2), 8'd0);
      check({tag, "_data_hold"}, 8'(rd2), 8'(exp));
   endtask

   // Counts cycles with req_ready low, starting right after reset is released.
   task automatic wait_ready(output int n);
      n = 0;
      while (r2 !== 1'b1 && n < 64) begin
         tick;
         n++;
      end
   endtask

   task automatic probe(input int sel, input int lat);
      int   k;
      logic rv;
      logic [2:0] rd;
      req_wren = 1'b1; req_address = 4'd2; req_data = 3'b100;
      if (sel == 1) v1 = 1'b1; else v15 = 1'b1;
      tick;
      v1 = 1'b0; v15 = 1'b0;
      k = 0;
      rv = (sel == 1) ? rv1 : rv15;
      while (rv !== 1'b1 && k < 40) begin
         tick;
         k++;
         rv = (sel == 1) ? rv1 : rv15;
      end
      rd = (sel == 1) ? rd1 : rd15;
      check($sformatf("lat%0d_edges", lat), 8'(k), 8'(lat));
      check($sformatf("lat%0d_data", lat), 8'(rd), 8'h4);
      tick;
      rv = (sel == 1) ? rv1 : rv15;
      check($sformatf("lat%0d_pulse_end", lat), 8'(rv), 8'd0);
   endtask

   initial begin
      int n;
      logic [2:0] exp3;
      reset = 1'b1; v2 = 1'b0; v1 = 1'b0; v15 = 1'b0;
      req_wren = 1'b0; req_address = 4'd0; req_data = 3'b000;
      repeat (3) tick;
      check("rst_rv", 8'(rv2), 8'd0);
      check("rst_rd", 8'(rd2), 8'd0);
      reset = 1'b0;

`ifdef MEM_CLEAR_ON_RESET_EN
      check("init_ready_low", 8'(r2), 8'd0);
      check("init_busy", 8'(b2), 8'd1);
      wait_ready(n);
      check("init_cycles", 8'(n), 8'd16);
      check("init_busy_done", 8'(b2), 8'd0);
      transact("init_rd0", 1'b0, 4'd0, 3'b000, 3'b000);
      transact("init_rd7", 1'b0, 4'd7, 3'b000, 3'b000);
      transact("init_rd15", 1'b0, 4'd15, 3'b000, 3'b000);
      reset = 1'b1; tick; reset = 1'b0;
      repeat (8) tick;
      reset = 1'b1; tick; reset = 1'b0;
      wait_ready(n);
      check("init_restart_cycles", 8'(n), 8'd16);
      exp3 = 3'b000;
`else
      check("rel_ready", 8'(r2), 8'd1);
      check("rel_busy", 8'(b2), 8'd0);
      tick;
      check("idle_ready", 8'(r2), 8'd1);
      check("idle_rv", 8'(rv2), 8'd0);
      check("idle_rd", 8'(rd2), 8'd0);
      exp3 = 3'b001;
`endif

      transact("wr5", 1'b1, 4'd5, 3'b110, 3'b110);
      transact("rd5", 1'b0, 4'd5, 3'b000, 3'b110);
      transact("wr9", 1'b1, 4'd9, 3'b011, 3'b011);

      // Second request held through WAIT, taken in the response cycle.
      req_wren = 1'b0; req_address = 4'd5; v2 = 1'b1;
      tick;
      req_address = 4'd9;
      check("b2b_ready_wait", 8'(r2), 8'd0);
      tick;
      check("b2b_rv_e1", 8'(rv2), 8'd0);
      tick;
      check("b2b_rv_first", 8'(rv2), 8'd1);
      check("b2b_data_first", 8'(rd2), 8'h6);
      check("b2b_ready_resp", 8'(r2), 8'd1);
      tick;
      v2 = 1'b0;
      check("b2b_accepted", 8'(b2), 8'd1);
      check("b2b_rv_gap", 8'(rv2), 8'd0);
      tick;
      check("b2b_rv_e1b", 8'(rv2), 8'd0);
      tick;
      check("b2b_rv_second", 8'(rv2), 8'd1);
      check("b2b_data_second", 8'(rd2), 8'h3);
      tick;
      check("b2b_rv_end", 8'(rv2), 8'd0);

      // Write aborted by reset in WAIT.
      transact("wr3", 1'b1, 4'd3, 3'b001, 3'b001);
      req_wren = 1'b1; req_address = 4'd3; req_data = 3'b111; v2 = 1'b1;
      tick;
      v2 = 1'b0;
      check("abort_busy", 8'(b2), 8'd1);
      tick;
      reset = 1'b1;
      tick;
      check("abort_rv", 8'(rv2), 8'd0);
      check("abort_rd", 8'(rd2), 8'd0);
      reset = 1'b0;
`ifdef MEM_CLEAR_ON_RESET_EN
      wait_ready(n);
      check("abort_init_cycles", 8'(n), 8'd16);
`else
      check("abort_ready", 8'(r2), 8'd1);
`endif
      tick;
      check("abort_rv_after", 8'(rv2), 8'd0);
      transact("rd3_after_abort", 1'b0, 4'd3, 3'b000, exp3);

      transact("wr0", 1'b1, 4'd0, 3'b101, 3'b101);
      transact("wr15", 1'b1, 4'd15, 3'b010, 3'b010);
      transact("rd0", 1'b0, 4'd0, 3'b000, 3'b101);
      transact("rd15", 1'b0, 4'd15, 3'b000, 3'b010);

      probe(1, 1);
      probe(15, 15);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
